// File: rtl/video_types_pkg.sv
// Shared video-subsystem types and constants: OAM geometry, the DMA register
// address, and the OAM DMA state encoding.
package video_types;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // Source pages E0-FF are the echo of C0-DF, so fold them back down.
    function automatic logic [7:0] echo_fold(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies XFER_LEN bytes from page {src_hi,00}
// into OAM, one byte every CYCLES_PER_BYTE clocks, after a one-M-cycle start delay.
module oam_dma
    import video_types::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int XFER_LEN        = OAM_LEN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    localparam int             PW     = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0]  P_ONE  = PW'(1);
    localparam logic [7:0]     I_LAST = 8'(XFER_LEN - 1);

    dma_state_t    state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [7:0]    src_hi;
    logic          ready;
    logic          reg_wr;
    logic [15:0]   dma_addr_q;
    logic [7:0]    oam_addr_q;
    logic [7:0]    oam_wdata_q;

    // A register write only counts once the block has seen one clock out of reset.
    assign reg_wr = ready && cpu_wr && (cpu_addr == DMA_REG_ADDR);

    // Reset-release qualifier: writes are ignored on the first edge after reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready <= 1'b0;
        else          ready <= 1'b1;
    end

    // DMA source register, readable by the CPU at all times.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    src_hi <= 8'h00;
        else if (reg_wr) src_hi <= cpu_wdata;
    end

    // State, phase and byte-index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: a register write always (re)starts from START.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_nxt = state;
        phase_nxt = phase;
        idx_nxt   = idx;
        if (reg_wr) begin
            state_nxt = START;
            phase_nxt = '0;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: ;
                START: begin
                    if (phase == P_LAST) begin
                        state_nxt = XFER;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + P_ONE;
                    end
                end
                XFER: begin
                    if (phase == P_ONE && idx == I_LAST) begin
                        state_nxt = IDLE;
                        phase_nxt = '0;
                        idx_nxt   = '0;
                    end else if (phase == P_LAST) begin
                        phase_nxt = '0;
                        idx_nxt   = idx + 8'd1;
                    end else begin
                        phase_nxt = phase + P_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    assign dma_rd     = (state == XFER) && (phase == '0);
    assign oam_we     = (state == XFER) && (phase == P_ONE);
    assign dma_active = (state != IDLE);
    assign cpu_rdata  = src_hi;

    // Address/data buses show the live value during their strobe and hold it afterwards.
    assign dma_addr  = dma_rd ? {echo_fold(src_hi), idx} : dma_addr_q;
    assign oam_addr  = oam_we ? idx : oam_addr_q;
    assign oam_wdata = oam_we ? dma_rdata : oam_wdata_q;

    // Hold registers that keep the bus values stable between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_addr_q  <= 16'h0000;
            oam_addr_q  <= 8'h00;
            oam_wdata_q <= 8'h00;
        end else begin
            if (dma_rd) dma_addr_q <= dma_addr;
            if (oam_we) begin
                oam_addr_q  <= oam_addr;
                oam_wdata_q <= oam_wdata;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a cycle-count model of the transfer timeline,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_oam_dma;

    localparam int C    = 4;
    localparam int LEN  = 160;
    localparam int LAST = LEN * C + 2;   // last active cycle, counted from 1

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_rdata;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;

    int vectors = 0;
    int miscompares = 0;

    oam_dma #(.CYCLES_PER_BYTE(C), .XFER_LEN(LEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_rdata(dma_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Source memory contents: page C1 holds index^5A, everything else a mixed pattern.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h33;
    endfunction

    // Source memory: data appears one clock after the read strobe.
    always @(posedge clk) dma_rdata <= dma_rd ? src_byte(dma_addr) : 8'hEE;

    // ---------------- behavioural model ----------------
    logic        m_ready = 1'b0, m_active = 1'b0, m_hit = 1'b0;
    int          m_k = 0, m_off = 0, m_i = 0, m_ph = 0;
    logic [7:0]  m_src = 8'h00, m_hi = 8'h00;
    logic        e_rd = 1'b0, e_we = 1'b0;
    logic [15:0] e_dma_addr = 16'h0000;
    logic [7:0]  e_oam_addr = 8'h00, e_oam_wdata = 8'h00;

    // The model numbers the cycles after a trigger 1..LAST; byte i's read lands
    // C+1+i*C cycles in and its OAM write one cycle later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ready = 0; m_active = 0; m_k = 0; m_src = 0; m_hi = 0;
            e_rd = 0; e_we = 0; e_dma_addr = 0; e_oam_addr = 0; e_oam_wdata = 0;
        end else begin
            m_hit   = m_ready && cpu_wr && (cpu_addr == 16'hFF46);
            m_ready = 1;
            if (m_hit) begin
                m_src    = cpu_wdata;
                m_hi     = (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
                m_active = 1;
                m_k      = 1;
            end else if (m_active) begin
                m_k++;
                if (m_k > LAST) m_active = 0;
            end
            e_rd = 0;
            e_we = 0;
            if (m_active && m_k >= C + 1) begin
                m_off = m_k - C - 1;
                m_i   = m_off / C;
                m_ph  = m_off % C;
                if (m_ph == 0) begin
                    e_rd = 1;
                    e_dma_addr = {m_hi, 8'(m_i)};
                end
                if (m_ph == 1) begin
                    e_we = 1;
                    e_oam_addr  = 8'(m_i);
                    e_oam_wdata = src_byte({m_hi, 8'(m_i)});
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        check("dma_rd",     {31'd0, dma_rd},     {31'd0, e_rd});
        check("oam_we",     {31'd0, oam_we},     {31'd0, e_we});
        check("dma_active", {31'd0, dma_active}, {31'd0, m_active});
        check("cpu_rdata",  {24'd0, cpu_rdata},  {24'd0, m_src});
        check("dma_addr",   {16'd0, dma_addr},   {16'd0, e_dma_addr});
        check("oam_addr",   {24'd0, oam_addr},   {24'd0, e_oam_addr});
        check("oam_wdata",  {24'd0, oam_wdata},  {24'd0, e_oam_wdata});
    end

    // ---------------- observation monitor ----------------
    int          cyc = 0;
    int          we_total = 0, rd_total = 0, rises = 0, active_total = 0, wr_cyc = 0;
    logic        prev_active = 1'b0;
    int          rd_cyc_q[$];
    logic [15:0] rd_addr_q[$];
    logic [7:0]  we_addr_q[$];
    logic [7:0]  oam_mem [256];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cpu_wr && cpu_addr == 16'hFF46) wr_cyc = cyc;
        if (dma_rd) begin
            rd_total++;
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(dma_addr);
        end
        if (oam_we) begin
            we_total++;
            we_addr_q.push_back(oam_addr);
            oam_mem[oam_addr] = oam_wdata;
        end
        if (dma_active) active_total++;
        if (dma_active && !prev_active) rises++;
        prev_active = dma_active;
    end

    function automatic logic [31:0] rd_addr_at(input int n);
        return (n < rd_addr_q.size()) ? {16'd0, rd_addr_q[n]} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] rd_cyc_at(input int n);
        return (n < rd_cyc_q.size()) ? rd_cyc_q[n] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] we_addr_at(input int n);
        return (n < we_addr_q.size()) ? {24'd0, we_addr_q[n]} : 32'hFFFF_FFFF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (dma_active && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, dma_active}, 32'd0);
    endtask

    task automatic wait_we_at(input string name, input logic [7:0] idx);
        int n = 0;
        @(negedge clk);
        while (!(oam_we && oam_addr == idx) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, oam_we}, 32'd1);
    endtask

    int s_rd, s_we, s_rise, s_act;

    task automatic snap();
        s_rd = rd_total; s_we = we_total; s_rise = rises; s_act = active_total;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_active", {31'd0, dma_active}, 32'd0);
        check("reset_rdata",  {24'd0, cpu_rdata},  32'h00);
        check("reset_addr",   {16'd0, dma_addr},   32'h0000);
        reset_n = 1'b1;

        // Full copy from page C1; this write lands on the second edge after release.
        snap();
        cpu_write(16'hFF46, 8'hC1);
        wait_idle("t1_idle");
        check("t1_we_count",  we_total - s_we, 160);
        check("t1_rd_latency", rd_cyc_at(s_rd) - wr_cyc, 5);
        check("t1_active_clocks", active_total - s_act, 642);
        check("t1_rdata", {24'd0, cpu_rdata}, 32'hC1);
        for (int i = 0; i < LEN; i++)
            check("t1_oam_byte", {24'd0, oam_mem[i]}, {24'd0, 8'(i) ^ 8'h5A});

        // Echo page E2 folds to C2.
        snap();
        cpu_write(16'hFF46, 8'hE2);
        wait_idle("t2_idle");
        check("t2_first_addr", rd_addr_at(s_rd), 32'hC200);
        check("t2_last_addr",  rd_addr_at(rd_total - 1), 32'hC29F);
        check("t2_rd_count",   rd_total - s_rd, 160);

        // Restart after 50 bytes.
        snap();
        cpu_write(16'hFF46, 8'hC0);
        wait_we_at("t3_reach_49", 8'd49);
        cpu_write(16'hFF46, 8'hD0);
        wait_idle("t3_idle");
        check("t3_restart_addr", rd_addr_at(s_rd + 50), 32'hD000);
        check("t3_restart_idx",  we_addr_at(s_we + 50), 32'h00);
        check("t3_we_count",     we_total - s_we, 210);
        check("t3_no_drop",      rises - s_rise, 1);

        // Reset at byte 80: outputs clear at once, nothing further happens.
        cpu_write(16'hFF46, 8'hC1);
        wait_we_at("t4_reach_79", 8'd79);
        #1 reset_n = 1'b0;
        #1;
        check("t4_rst_rd",     {31'd0, dma_rd},     32'd0);
        check("t4_rst_we",     {31'd0, oam_we},     32'd0);
        check("t4_rst_active", {31'd0, dma_active}, 32'd0);
        check("t4_rst_daddr",  {16'd0, dma_addr},   32'h0000);
        check("t4_rst_oaddr",  {24'd0, oam_addr},   32'h00);
        check("t4_rst_wdata",  {24'd0, oam_wdata},  32'h00);
        check("t4_rst_rdata",  {24'd0, cpu_rdata},  32'h00);
        snap();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cpu_addr = 16'hFF46; cpu_wdata = 8'h44; cpu_wr = 1'b1;   // first edge: ignored
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        repeat (200) @(negedge clk);
        check("t4_no_rd", rd_total - s_rd, 0);
        check("t4_no_we", we_total - s_we, 0);
        check("t4_rdata", {24'd0, cpu_rdata}, 32'h00);

        // Write on the second edge after release is honoured.
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        cpu_addr = 16'hFF46; cpu_wdata = 8'h55; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        check("t4b_started", {31'd0, dma_active}, 32'd1);
        check("t4b_rdata",   {24'd0, cpu_rdata},  32'h55);
        wait_idle("t4b_idle");

        // Other addresses are ignored.
        snap();
        cpu_write(16'hFF45, 8'h12);
        repeat (20) @(negedge clk);
        check("t5_rdata",  {24'd0, cpu_rdata}, 32'h55);
        check("t5_no_rise", rises - s_rise, 0);

        // Back-to-back writes: one transfer from the second value.
        snap();
        @(posedge clk); #1;
        cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wdata = 8'hC3;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        wait_idle("t6_idle");
        check("t6_first_addr", rd_addr_at(s_rd), 32'hC300);
        check("t6_latency",    rd_cyc_at(s_rd) - wr_cyc, 5);
        check("t6_we_count",   we_total - s_we, 160);
        check("t6_rises",      rises - s_rise, 1);
        check("t6_active_clocks", active_total - s_act, 643);

        // Write coinciding with the final OAM write: finishes, then restarts.
        snap();
        cpu_write(16'hFF46, 8'hC1);
        wait_we_at("t7_reach_159", 8'd159);
        cpu_addr = 16'hFF46; cpu_wdata = 8'hC2; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        wait_idle("t7_idle");
        check("t7_we_count", we_total - s_we, 320);
        check("t7_rises",    rises - s_rise, 1);
        check("t7_second_src", rd_addr_at(s_rd + 160), 32'hC200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_BYTE, default 4, meaning clocks per transferred byte (one M-cycle); legal range is 2 or more.
REQ-002 The block SHALL have parameter XFER_LEN, default 160, meaning bytes per transfer (OAM size).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cpu_addr, input, 16 bits: CPU bus address.
REQ-006 The block SHALL have port cpu_wdata, input, 8 bits: CPU write data.
REQ-007 The block SHALL have port cpu_wr, input, 1 bit: single-cycle CPU write strobe.
REQ-008 The block SHALL have port cpu_rdata, output, 8 bits: readback of the DMA source register.
REQ-009 The block SHALL have port dma_addr, output, 16 bits: source read address.
REQ-010 The block SHALL have port dma_rd, output, 1 bit: source read strobe.
REQ-011 The block SHALL have port dma_rdata, input, 8 bits: source data, valid exactly 1 clock after dma_rd.
REQ-012 The block SHALL have port oam_addr, output, 8 bits: OAM byte index.
REQ-013 The block SHALL have port oam_wdata, output, 8 bits: OAM write data.
REQ-014 The block SHALL have port oam_we, output, 1 bit: OAM write strobe to the graphics block.
REQ-015 The block SHALL have port dma_active, output, 1 bit: transfer in progress; the CPU sees the bus locked and the PPU is denied OAM.

Function
REQ-016 A cpu_wr with cpu_addr equal to 16'hFF46 SHALL latch cpu_wdata into src_hi; cpu_rdata SHALL always equal src_hi.
REQ-017 The state machine SHALL have states IDLE, START, XFER.
- IDLE to START on a FF46 write.
- START lasts CYCLES_PER_BYTE clocks, then goes to XFER.
- XFER to IDLE after the final oam_we.
REQ-018 Effective source high byte SHALL be src_hi minus 8'h20 when src_hi is 8'hE0 or above (echo mirror); otherwise it SHALL be src_hi.
REQ-019 In XFER, with byte index i (0 to XFER_LEN-1) and phase p (0 to CYCLES_PER_BYTE-1), the block SHALL, at p equal to 0, drive dma_rd high for 1 clock with dma_addr equal to {effective source high byte, i}.
REQ-020 At p equal to 1, the block SHALL drive oam_we high for 1 clock, with oam_addr equal to i and oam_wdata equal to the dma_rdata captured at p equal to 1.
REQ-021 dma_rd and oam_we SHALL otherwise be low; dma_addr, oam_addr and oam_wdata SHALL hold their last values when their strobes are low.
REQ-022 The byte index counter SHALL be 8 bits; after the strobe at i equal to XFER_LEN-1 the block SHALL return to IDLE without wrapping to 0.
REQ-023 dma_active SHALL be high from the clock after the triggering write through the clock of the last oam_we inclusive.
- Total high time is (XFER_LEN+1)*CYCLES_PER_BYTE-(CYCLES_PER_BYTE-2) clocks.
REQ-024 A FF46 write during START or XFER SHALL restart the transfer: latch the new src_hi, go to START, reset i and p to 0, and leave dma_active high continuously.
REQ-025 A FF46 write in the same clock as the final oam_we SHALL let that final write complete, then enter START.
REQ-026 CPU writes to addresses other than 16'hFF46 SHALL be ignored.

Reset
REQ-027 Asserting reset_n low SHALL immediately force IDLE, src_hi to 8'h00, i and p to 0, dma_rd, oam_we and dma_active to 0, and dma_addr, oam_addr and oam_wdata to 0.
REQ-028 Reset mid-transfer SHALL abort the transfer with no further strobes; OAM contents already written are not rolled back.
REQ-029 Reset release SHALL be synchronous: the first FF46 write is honoured on the second clock edge after reset_n rises.

Structure
REQ-030 DMA_REG_ADDR (16'hFF46), OAM_BASE (16'hFE00), the OAM length (160) and the dma_state_t enum SHALL live in the shared video_types package.
REQ-031 No sub-module is needed; the phase and index counters stay inline.

Verification
REQ-032 Write 8'hC1 to FF46 against a model memory with C100-C19F set to index XOR 8'h5A: the bench SHALL see 160 oam_we pulses, OAM[i] equal to i XOR 8'h5A, the first dma_rd exactly 5 clocks after cpu_wr, and dma_active high for 642 clocks.
REQ-033 Write 8'hE2: the bench SHALL see dma_addr run from 16'hC200 to 16'hC29F.
REQ-034 Write 8'hC0, then write 8'hD0 after 50 bytes: the bench SHALL see the index restart at 0, dma_addr equal to 16'hD000, dma_active never drop, and a total of 210 oam_we pulses.
REQ-035 Pulse reset_n low for 3 clocks at byte 80: the bench SHALL see all outputs go to 0 asynchronously within the same cycle, no strobes afterward, and cpu_rdata equal to 8'h00.
REQ-036 Write 8'h12 to FF45, then read: the bench SHALL see no transfer start and cpu_rdata unchanged.
REQ-037 Write the same address twice back-to-back: the bench SHALL see a single clean transfer starting from the second write.
